// File: rtl/radar_sync_controller.sv
// Radar simulator sequencer: calibration wait, ARP lock, azimuth tracking,
// gated TRIG forwarding and loss-of-signal / ACP-count supervision.
module radar_sync_controller #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_SHIFT  = 1,
  parameter int MISMATCH_LIMIT = 2
) (
  input  logic                  S_AXIS_ACLK,
  input  logic                  S_AXIS_ARESET,
  input  logic                  ENABLE,
  input  logic                  CLR_ERR,
  input  logic                  RADAR_ARP_PE,
  input  logic                  RADAR_ACP_PE,
  input  logic                  RADAR_TRIG_PE,
  input  logic                  USEC_PE,
  input  logic                  CALIBRATED,
  input  logic [DATA_WIDTH-1:0] RADAR_ARP_US,
  input  logic [DATA_WIDTH-1:0] RADAR_ACP_CNT,
  input  logic [DATA_WIDTH-1:0] RADAR_TRIG_US,
  output logic [2:0]            STATE,
  output logic                  SIM_EN,
  output logic [DATA_WIDTH-1:0] AZIMUTH,
  output logic                  TRIG_OUT,
  output logic                  ERR_ARP_TIMEOUT,
  output logic                  ERR_TRIG_TIMEOUT,
  output logic                  ERR_ACP_MISMATCH
);

  localparam int DW = DATA_WIDTH;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WCAL  = 3'd1;
  localparam logic [2:0] S_SYNC  = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;
  localparam logic [DW-1:0] ONES = '1;
  localparam logic [3:0] MM_LIM = 4'(MISMATCH_LIMIT);

  logic [2:0]    state, state_nxt, norm_nxt;
  logic [DW-1:0] arp_wd, trig_wd, arp_wd_nxt, trig_wd_nxt;
  logic [DW-1:0] acp_turn, az, az_max, acp_ld;
  logic [DW:0]   arp_lim, trig_lim;
  logic [3:0]    mm_cnt, mm_nxt;
  logic          active, in_run, sync_entry, run_entry;
  logic          arp_to, trig_to, mism, mm_fault;

  assign active     = (state == S_SYNC) || (state == S_RUN);
  assign in_run     = (state == S_RUN);
  assign sync_entry = (state != S_SYNC) && (state_nxt == S_SYNC);
  assign run_entry  = (state == S_SYNC) && (state_nxt == S_RUN);
  assign acp_ld     = {{(DW-1){1'b0}}, RADAR_ACP_PE};
  assign az_max     = (RADAR_ACP_CNT == '0) ? '0
                    : RADAR_ACP_CNT - DW'(1);

  assign arp_lim  = {1'b0, RADAR_ARP_US}
                  + {1'b0, RADAR_ARP_US >> TIMEOUT_SHIFT};
  assign trig_lim = {1'b0, RADAR_TRIG_US}
                  + {1'b0, RADAR_TRIG_US >> TIMEOUT_SHIFT};

  // Watchdog next values: restart on the reference pulse, else saturating count
  always_comb begin
    arp_wd_nxt  = arp_wd;
    trig_wd_nxt = trig_wd;
    if (RADAR_ARP_PE)
      arp_wd_nxt = {{(DW-1){1'b0}}, USEC_PE};
    else if (USEC_PE && arp_wd != ONES)
      arp_wd_nxt = arp_wd + DW'(1);
    if (RADAR_TRIG_PE)
      trig_wd_nxt = {{(DW-1){1'b0}}, USEC_PE};
    else if (USEC_PE && trig_wd != ONES)
      trig_wd_nxt = trig_wd + DW'(1);
  end

  assign arp_to  = active && (RADAR_ARP_US != '0)
                && ({1'b0, arp_wd_nxt} > arp_lim);
  assign trig_to = in_run && (RADAR_TRIG_US != '0)
                && ({1'b0, trig_wd_nxt} > trig_lim);
  assign mism    = in_run && RADAR_ARP_PE
                && (acp_turn != RADAR_ACP_CNT);

  // Consecutive-mismatch counter: bumps on a bad turn, clears on a good one
  always_comb begin
    mm_nxt = mm_cnt;
    if (mism)
      mm_nxt = (mm_cnt == 4'hF) ? mm_cnt : mm_cnt + 4'd1;
    else if (in_run && RADAR_ARP_PE)
      mm_nxt = '0;
  end

  assign mm_fault = mism && (mm_nxt >= MM_LIM);

  // Next state: enable drop, then error clear, then faults, then sequencing
  always_comb begin
    case (state)
      S_IDLE:  norm_nxt = S_WCAL;
      S_WCAL:  norm_nxt = CALIBRATED ? S_SYNC : S_WCAL;
      S_SYNC:  norm_nxt = RADAR_ARP_PE ? S_RUN : S_SYNC;
      S_RUN:   norm_nxt = S_RUN;
      S_FAULT: norm_nxt = S_FAULT;
      default: norm_nxt = S_IDLE;
    endcase
    state_nxt = norm_nxt;
    if (!ENABLE)
      state_nxt = S_IDLE;
    else if (CLR_ERR)
      state_nxt = (state == S_FAULT) ? S_WCAL : norm_nxt;
    else if (arp_to || trig_to || mm_fault)
      state_nxt = S_FAULT;
  end

  // Registered state, outputs, watchdogs, azimuth and error bookkeeping
  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      state            <= S_IDLE;
      SIM_EN           <= 1'b0;
      TRIG_OUT         <= 1'b0;
      az               <= '0;
      acp_turn         <= '0;
      arp_wd           <= '0;
      trig_wd          <= '0;
      mm_cnt           <= '0;
      ERR_ARP_TIMEOUT  <= 1'b0;
      ERR_TRIG_TIMEOUT <= 1'b0;
      ERR_ACP_MISMATCH <= 1'b0;
    end else begin
      state    <= state_nxt;
      SIM_EN   <= (state_nxt == S_RUN);
      TRIG_OUT <= RADAR_TRIG_PE && in_run && ENABLE;
      if (ENABLE && CLR_ERR) begin
        ERR_ARP_TIMEOUT  <= 1'b0;
        ERR_TRIG_TIMEOUT <= 1'b0;
        ERR_ACP_MISMATCH <= 1'b0;
        mm_cnt           <= '0;
      end else if (ENABLE) begin
        ERR_ARP_TIMEOUT  <= ERR_ARP_TIMEOUT | arp_to;
        ERR_TRIG_TIMEOUT <= ERR_TRIG_TIMEOUT | trig_to;
        ERR_ACP_MISMATCH <= ERR_ACP_MISMATCH | mism;
        mm_cnt           <= mm_nxt;
      end
      if (sync_entry) begin
        arp_wd  <= '0;
        trig_wd <= '0;
      end else begin
        if (active) arp_wd  <= arp_wd_nxt;
        if (in_run) trig_wd <= trig_wd_nxt;
      end
      if (run_entry) begin
        az       <= acp_ld;
        acp_turn <= acp_ld;
      end else if (in_run) begin
        if (RADAR_ARP_PE) begin
          az       <= acp_ld;
          acp_turn <= acp_ld;
        end else if (RADAR_ACP_PE) begin
          acp_turn <= acp_turn + DW'(1);
          if (az < az_max) az <= az + DW'(1);
        end
      end
    end
  end

  assign STATE   = state;
  assign AZIMUTH = az;

endmodule

// File: tb/tb_radar_sync_controller.sv
// Bench for radar_sync_controller: directed plan sequences, a vector table
// and randomized traffic against a behavioural model.
module tb_radar_sync_controller;

  localparam int TS  = 1;
  localparam int LIM = 2;
  localparam longint unsigned MAXV = 64'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst, en, clr, arp, acp, trig, usec, cal;
  logic [31:0] arp_us, acp_cnt, trig_us;
  logic [2:0]  st;
  logic        sim, tout, e_a, e_t, e_m;
  logic [31:0] az;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  radar_sync_controller #(
    .DATA_WIDTH(32), .TIMEOUT_SHIFT(TS), .MISMATCH_LIMIT(LIM)
  ) dut (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESET(rst), .ENABLE(en),
    .CLR_ERR(clr), .RADAR_ARP_PE(arp), .RADAR_ACP_PE(acp),
    .RADAR_TRIG_PE(trig), .USEC_PE(usec), .CALIBRATED(cal),
    .RADAR_ARP_US(arp_us), .RADAR_ACP_CNT(acp_cnt),
    .RADAR_TRIG_US(trig_us), .STATE(st), .SIM_EN(sim),
    .AZIMUTH(az), .TRIG_OUT(tout), .ERR_ARP_TIMEOUT(e_a),
    .ERR_TRIG_TIMEOUT(e_t), .ERR_ACP_MISMATCH(e_m)
  );

  // behavioural model (mode numbers follow the STATE output code)
  int m_mode, m_mm;
  bit m_sim, m_tout, m_ea, m_et, m_em;
  longint unsigned m_az, m_us_arp, m_us_trig;
  logic [31:0] m_turn;

  task automatic model_step();
    longint unsigned la, lt, na, nt, amax;
    bit live, running, a_to, t_to, bad;
    int nxt, nmm, seq;
    if (rst) begin
      m_mode = 0; m_sim = 0; m_tout = 0; m_az = 0; m_turn = 0;
      m_us_arp = 0; m_us_trig = 0; m_mm = 0;
      m_ea = 0; m_et = 0; m_em = 0;
      return;
    end
    running = (m_mode == 3);
    live = (m_mode == 2) || running;
    la = longint'(arp_us) + longint'(arp_us >> TS);
    lt = longint'(trig_us) + longint'(trig_us >> TS);
    na = arp ? longint'(usec) : m_us_arp + longint'(usec);
    if (na > MAXV) na = MAXV;
    nt = trig ? longint'(usec) : m_us_trig + longint'(usec);
    if (nt > MAXV) nt = MAXV;
    a_to = live && arp_us != 0 && na > la;
    t_to = running && trig_us != 0 && nt > lt;
    bad = running && arp && (m_turn != acp_cnt);
    nmm = m_mm;
    if (bad) nmm = (m_mm < 15) ? m_mm + 1 : 15;
    else if (running && arp) nmm = 0;
    case (m_mode)
      0: seq = 1;
      1: seq = cal ? 2 : 1;
      2: seq = arp ? 3 : 2;
      3: seq = 3;
      default: seq = 4;
    endcase
    if (!en) nxt = 0;
    else if (clr) begin
      nxt = (m_mode == 4) ? 1 : seq;
      m_ea = 0; m_et = 0; m_em = 0; m_mm = 0;
    end else begin
      nxt = (a_to || t_to || (bad && nmm >= LIM)) ? 4 : seq;
      m_ea |= a_to; m_et |= t_to; m_em |= bad; m_mm = nmm;
    end
    if (nxt == 2 && m_mode != 2) begin
      m_us_arp = 0; m_us_trig = 0;
    end else begin
      if (live) m_us_arp = na;
      if (running) m_us_trig = nt;
    end
    amax = (acp_cnt == 0) ? 0 : longint'(acp_cnt) - 1;
    if ((m_mode == 2 && nxt == 3) || (running && arp)) begin
      m_az = acp; m_turn = acp;
    end else if (running && acp) begin
      m_turn = m_turn + 1;
      if (m_az < amax) m_az = m_az + 1;
    end
    m_tout = trig && running && en;
    m_sim = (nxt == 3);
    m_mode = nxt;
  endtask

  task automatic check_model();
    vectors++;
    if (st !== 3'(m_mode) || sim !== m_sim || tout !== m_tout ||
        az !== 32'(m_az) || e_a !== m_ea || e_t !== m_et ||
        e_m !== m_em) begin
      miscompares++;
      $display("FAIL model t=%0t st=%0d/%0d sim=%b/%b tout=%b/%b az=%0d/%0d err=%b%b%b/%b%b%b",
        $time, st, m_mode, sim, m_sim, tout, m_tout, az, m_az,
        e_a, e_t, e_m, m_ea, m_et, m_em);
    end
  endtask

  task automatic chk(input string name, input longint act,
                     input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic pulses(input bit a, input bit c, input bit t,
                        input bit u);
    arp = a; acp = c; trig = t; usec = u;
  endtask

  task automatic idle_in();
    rst = 0; clr = 0; pulses(0, 0, 0, 0);
  endtask

  // WAIT_CAL -> SYNC -> RUN with quiet pulses
  task automatic go_run();
    idle_in(); en = 1; cal = 1; tick();
    cal = 0; arp = 1; tick();
    idle_in();
  endtask

  typedef struct {
    bit r, e, c, k, a, p, t;
    int st; bit sim; bit tout; int az;
  } vec_t;
  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1,0,0,0,0,0,0, 0,0,0,0};
    tbl[1]  = '{0,1,0,0,0,0,0, 1,0,0,0};
    tbl[2]  = '{0,1,0,1,0,0,0, 2,0,0,0};
    tbl[3]  = '{0,1,0,1,1,1,0, 3,1,0,1};
    tbl[4]  = '{0,1,0,0,0,1,1, 3,1,1,2};
    tbl[5]  = '{0,1,0,0,0,0,0, 3,1,0,2};
    tbl[6]  = '{0,0,0,0,0,0,1, 0,0,0,2};
    tbl[7]  = '{0,1,0,1,0,0,0, 1,0,0,2};
    tbl[8]  = '{0,1,0,1,0,0,0, 2,0,0,2};
    tbl[9]  = '{0,1,0,0,0,1,0, 2,0,0,2};
    tbl[10] = '{0,1,0,0,1,0,0, 3,1,0,0};
    tbl[11] = '{1,1,0,0,0,0,1, 0,0,0,0};

    rst = 1; en = 0; clr = 0; cal = 0; pulses(0, 0, 0, 0);
    arp_us = 1000; acp_cnt = 4096; trig_us = 0;
    tick(); tick();
    chk("reset_state", st, 0);
    chk("reset_sim_en", sim, 0);

    // calibration path
    rst = 0; en = 1;
    for (int c = 0; c <= 50; c++) begin
      cal = (c >= 10); arp = (c == 50);
      tick();
      if (c == 0)  chk("cal_state_c1", st, 1);
      if (c == 9)  chk("cal_state_c10", st, 1);
      if (c == 10) chk("cal_state_c11", st, 2);
      if (c == 49) chk("cal_state_c50", st, 2);
    end
    chk("cal_state_c51", st, 3);
    chk("cal_sim_en_c51", sim, 1);
    chk("cal_az_c51", az, 0);
    idle_in(); cal = 0;

    // azimuth tracking over one full turn
    for (int i = 1; i <= 4096; i++) begin
      acp = 1; tick();
      if (i == 1 || i == 2 || i == 4095 || i == 4096)
        chk("az_track", az, (i < 4095) ? i : 4095);
    end
    acp = 0; arp = 1; tick(); arp = 0;
    chk("az_after_arp", az, 0);
    chk("az_no_mismatch", e_m, 0);

    // mismatch sequence: 4095, 4096, 4095, 4095 ACPs per turn
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < ((t == 1) ? 4096 : 4095); i++) begin
        acp = 1; tick();
      end
      acp = 0; arp = 1; tick(); arp = 0;
      chk("mm_state", st, (t == 3) ? 4 : 3);
      chk("mm_flag", e_m, (t == 1) ? 1 : 1);
    end
    chk("mm_sim_en", sim, 0);
    clr = 1; tick(); clr = 0;
    chk("mm_clr_state", st, 1);
    chk("mm_clr_flag", e_m, 0);

    // ARP loss
    arp_us = 1000; trig_us = 0;
    go_run();
    chk("arp_loss_run", st, 3);
    usec = 1;
    for (int i = 1; i <= 1501; i++) begin
      tick();
      if (i == 1500) chk("arp_loss_1500", st, 3);
    end
    usec = 0;
    chk("arp_loss_state", st, 4);
    chk("arp_loss_flag", e_a, 1);
    chk("arp_loss_sim_en", sim, 0);
    clr = 1; tick(); clr = 0;
    chk("arp_clr_state", st, 1);
    chk("arp_clr_flag", e_a, 0);

    // TRIG loss
    arp_us = 0; trig_us = 1000;
    go_run();
    trig = 1; tick(); trig = 0;
    chk("trig_fwd", tout, 1);
    usec = 1;
    for (int i = 1; i <= 1501; i++) begin
      tick();
      if (i == 1500) chk("trig_loss_1500", st, 3);
    end
    usec = 0;
    chk("trig_loss_state", st, 4);
    chk("trig_loss_flag", e_t, 1);
    trig = 1; tick(); trig = 0;
    chk("trig_gated_fault", tout, 0);
    clr = 1; tick(); clr = 0;
    chk("trig_clr_flag", e_t, 0);

    // TRIG period 0 disables its watchdog
    trig_us = 0;
    go_run();
    usec = 1;
    for (int i = 0; i < 3000; i++) tick();
    usec = 0;
    chk("trig_off_state", st, 3);
    chk("trig_off_flag", e_t, 0);

    // overrides: ENABLE=0 keeps sticky flags, reset clears them
    arp = 1; tick(); arp = 0;
    chk("ovr_flag_set", e_m, 1);
    en = 0; trig = 1; tick(); trig = 0;
    chk("ovr_en0_state", st, 0);
    chk("ovr_en0_flag", e_m, 1);
    chk("ovr_en0_trig", tout, 0);
    rst = 1; tick(); rst = 0;
    chk("ovr_rst_flag", e_m, 0);

    // vector table
    for (int i = 0; i < 12; i++) begin
      rst = tbl[i].r; en = tbl[i].e; clr = tbl[i].c;
      cal = tbl[i].k;
      pulses(tbl[i].a, tbl[i].p, tbl[i].t, 0);
      tick();
      chk($sformatf("tbl%0d_state", i), st, tbl[i].st);
      chk($sformatf("tbl%0d_sim", i), sim, tbl[i].sim);
      chk($sformatf("tbl%0d_trig", i), tout, tbl[i].tout);
      chk($sformatf("tbl%0d_az", i), az, tbl[i].az);
    end

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) begin
        arp_us  = ($urandom % 6 == 0) ? 32'hFFFF_FFFF
                : $urandom_range(0, 30);
        trig_us = $urandom_range(0, 15);
        acp_cnt = $urandom_range(0, 10);
      end
      rst  = ($urandom % 500 == 0);
      en   = ($urandom % 40 != 0);
      clr  = ($urandom % 60 == 0);
      cal  = ($urandom % 4 != 0);
      arp  = ($urandom % 25 == 0);
      acp  = ($urandom % 3 == 0);
      trig = ($urandom % 6 == 0);
      usec = ($urandom % 2 == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
